jpeg_stream_reader: RTL and testbench

- Bus initiator that drains the compressed stream from the JPEG encoder peripheral over XBAR_PERIPH_BUS. It polls the encoder FIFO-depth register, reads that many data words, and forwards them on a valid/ready stream to a downstream DMA/packer.
- After the encoder's end interrupt, it reads the end-of-stream bit-count register and emits one trailer beat. It then signals done.

---
 rtl/jpeg_stream_reader.sv | 124 ++++++++++++
 tb/tb_jpeg_stream_reader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_stream_reader.sv
// jpeg_stream_reader: drains the JPEG encoder FIFO over XBAR_PERIPH_BUS onto a valid/ready stream.
// Define JPEG_RD_TIMEOUT_EN to add a response watchdog with an err pulse output.
module jpeg_stream_reader #(
  parameter logic [31:0]         BASE_ADDR = 32'h0,
  parameter int                  ID_WIDTH  = 5,
  parameter logic [ID_WIDTH-1:0] MY_ID     = '0,
  parameter int                  POLL_GAP  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                end_irq,
  output logic                req,
  output logic [31:0]         add,
  output logic                wen,
  output logic [31:0]         wdata,
  output logic [3:0]          be,
  output logic [ID_WIDTH-1:0] id,
  input  logic                gnt,
  input  logic                r_valid,
  input  logic [31:0]         r_rdata,
  input  logic [ID_WIDTH-1:0] r_id,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [31:0]         m_data,
  output logic                m_last,
  output logic                busy,
`ifdef JPEG_RD_TIMEOUT_EN
  output logic                err,
`endif
  output logic                done
);
  localparam logic [3:0] IDLE = 4'd0, POLL = 4'd1, POLL_W = 4'd2, GAP = 4'd3, DRAIN = 4'd4,
                         DRAIN_W = 4'd5, EOFB = 4'd6, EOFB_W = 4'd7, TRAIL = 4'd8, DONE = 4'd9;
  logic [3:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [7:0]  tmr_q, tmr_d;
  logic        end_flag_q, end_flag_d, end_seen_q, end_seen_d;
  logic        hold_v_q, hold_v_d, last_q, last_d;
  logic [31:0] hold_q, hold_d;
  logic        rsp, fire;
  assign req     = (state_q == POLL) | (state_q == DRAIN & (~hold_v_q | m_ready)) | (state_q == EOFB & ~hold_v_q);
  assign add     = !req ? 32'h0 : state_q == POLL ? BASE_ADDR + 32'h200 : state_q == EOFB ? BASE_ADDR + 32'h300 : BASE_ADDR;
  assign wen     = 1'b1;
  assign wdata   = 32'h0;
  assign be      = 4'hF;
  assign id      = MY_ID;
  assign m_valid = hold_v_q;
  assign m_data  = hold_q;
  assign m_last  = last_q;
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign rsp     = r_valid && r_id == MY_ID;
  assign fire    = req & gnt;
`ifdef JPEG_RD_TIMEOUT_EN
  assign err     = (state_q == POLL_W || state_q == DRAIN_W || state_q == EOFB_W) && tmr_q == 8'hFF;
`endif
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    end_seen_d = end_seen_q;
    end_flag_d = (state_q == IDLE && start) ? 1'b0 : end_flag_q | (end_irq & busy);
    hold_v_d   = hold_v_q & ~m_ready;
    hold_d     = hold_q;
    last_d     = last_q;
    case (state_q)
      IDLE:    state_d = start ? POLL : IDLE;
      POLL:    if (fire) begin
        end_seen_d = end_flag_q;
        state_d    = POLL_W;
      end
      POLL_W:  if (rsp) begin
        cnt_d   = r_rdata[5:0];
        state_d = r_rdata[5:0] != 6'd0 ? DRAIN : end_seen_q ? EOFB : POLL_GAP == 0 ? POLL : GAP;
      end
      GAP:     state_d = tmr_q == 8'(POLL_GAP - 1) ? POLL : GAP;
      DRAIN:   state_d = fire ? DRAIN_W : DRAIN;
      DRAIN_W: if (rsp) begin
        hold_v_d = 1'b1;
        hold_d   = r_rdata;
        last_d   = 1'b0;
        cnt_d    = cnt_q - 6'd1;
        state_d  = cnt_q == 6'd1 ? POLL : DRAIN;
      end
      EOFB:    state_d = fire ? EOFB_W : EOFB;
      EOFB_W:  if (rsp) begin
        hold_v_d = 1'b1;
        hold_d   = {27'b0, r_rdata[4:0]};
        last_d   = 1'b1;
        state_d  = TRAIL;
      end
      TRAIL:   state_d = (hold_v_q & m_ready) ? DONE : TRAIL;
      default: state_d = IDLE;
    endcase
`ifdef JPEG_RD_TIMEOUT_EN
    if (err) begin
      state_d  = IDLE;
      hold_v_d = 1'b0;
    end
`endif
    // shared timer: GAP length and response watchdog, restarted on every state change
    tmr_d = state_d != state_q ? 8'd0 : tmr_q + 8'd1;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tmr_q      <= '0;
      end_flag_q <= 1'b0;
      end_seen_q <= 1'b0;
      hold_v_q   <= 1'b0;
      hold_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      end_flag_q <= end_flag_d;
      end_seen_q <= end_seen_d;
      hold_v_q   <= hold_v_d;
      hold_q     <= hold_d;
      last_q     <= last_d;
    end
endmodule

// File: tb/tb_jpeg_stream_reader.sv
// tb_jpeg_stream_reader: directed scenarios against a bus-slave model and a stream monitor.
module tb_jpeg_stream_reader;
  localparam logic [4:0] MY_ID = 5'd0;
  logic        clk = 0, rst_n = 0, start = 0, end_irq = 0;
  logic        req, wen, gnt = 0, r_valid = 0, m_valid, m_ready = 0, m_last, busy, done;
  logic [31:0] add, wdata, m_data, r_rdata = 0;
  logic [3:0]  be;
  logic [4:0]  id, r_id = 0;
  int checks = 0, failures = 0, cyc = 0;
  int gnt_dly = 0, resp_wait = 0, wait_n = 0, stall_n = 0, stall_bad = 0;
  bit foreign = 0, foreign_done = 0, pend = 0, prev_stall = 0;
  logic [31:0] resp_val = 0, stall_add = 0, endbits = 0, prev_data = 0;
  logic [31:0] depth_q[$], bq_d[$];
  logic        bq_l[$];
  int poll_cyc[$], poll_rq[$];
  int n_poll = 0, n_data = 0, n_endb = 0, data_n = 0, req_hi = 0, full_rd = 0, data_moved = 0, done_cnt = 0;

  jpeg_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .end_irq(end_irq),
    .req(req), .add(add), .wen(wen), .wdata(wdata), .be(be), .id(id),
    .gnt(gnt), .r_valid(r_valid), .r_rdata(r_rdata), .r_id(r_id),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // bus slave: grant after gnt_dly stalled cycles, answer after resp_wait cycles
  initial forever begin
    @(negedge clk);
    #2;
    gnt = 0;
    r_valid = 0;
    r_id = MY_ID;
    if (pend) begin
      if (wait_n > 0) wait_n--;
      else if (foreign && !foreign_done) begin
        r_valid = 1; r_id = MY_ID + 5'd3; r_rdata = 32'hBAD0_BAD0; foreign_done = 1;
      end else begin
        r_valid = 1; r_rdata = resp_val; pend = 0;
      end
    end
    if (req) begin
      req_hi++;
      if (add == 32'h0 && m_valid && !m_ready) full_rd++;
      if (pend) stall_bad++;
      if (stall_n == 0) stall_add = add;
      else if (add !== stall_add) stall_bad++;
      if (stall_n >= gnt_dly) begin
        gnt = 1; stall_n = 0; pend = 1; wait_n = resp_wait; foreign_done = 0;
        if (add == 32'h200) begin
          n_poll++;
          poll_cyc.push_back(cyc);
          poll_rq.push_back(req_hi);
          if (depth_q.size() > 0) resp_val = depth_q.pop_front();
          else resp_val = 32'h0;
        end else if (add == 32'h300) begin
          n_endb++;
          resp_val = endbits;
        end else begin
          n_data++;
          resp_val = 32'hD000_0000 + 32'(data_n);
          data_n++;
        end
      end else stall_n++;
    end else if (stall_n != 0) begin
      stall_bad++;
      stall_n = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    #3;
    if (m_valid && m_ready) begin
      bq_d.push_back(m_data);
      bq_l.push_back(m_last);
    end
    if (done) done_cnt++;
    if (prev_stall && (!m_valid || m_data !== prev_data)) data_moved++;
    prev_stall = m_valid && !m_ready;
    prev_data = m_data;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic clear;
    bq_d.delete(); bq_l.delete(); depth_q.delete(); poll_cyc.delete(); poll_rq.delete();
    data_n = 0; n_poll = 0; n_data = 0; n_endb = 0; stall_bad = 0; full_rd = 0; data_moved = 0;
  endtask

  task automatic pulse_start;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic wait_done(input int max);
    int d0 = done_cnt;
    for (int i = 0; i < max && done_cnt == d0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    #4;
    checks++;
    if ({req, add, wen, wdata, be, id} !== {1'b0, 32'h0, 1'b1, 32'h0, 4'hF, 5'h0}) begin
      failures++;
      $display("FAIL reset_bus: got %h want %h", {req, add, wen, wdata, be, id}, {1'b0, 32'h0, 1'b1, 32'h0, 4'hF, 5'h0});
    end
    checks++;
    if ({m_valid, m_data, m_last, busy, done} !== 36'h0) begin
      failures++;
      $display("FAIL reset_stream: got %h want 0", {m_valid, m_data, m_last, busy, done});
    end
    rst_n = 1;
  endtask

  task automatic test_basic;
    int d0;
    logic [32:0] e;
    clear(); endbits = 32'h13; depth_q = '{32'd3, 32'd0}; m_ready = 1; d0 = done_cnt;
    pulse_start();
    end_irq = 1; @(negedge clk); end_irq = 0;
    wait_done(300);
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL basic_done: got %0d want 1", done_cnt - d0); end
    checks++;
    if (bq_d.size() != 4) begin failures++; $display("FAIL basic_beats: got %0d want 4", bq_d.size()); end
    for (int i = 0; i < bq_d.size(); i++) begin
      e = i == 3 ? {1'b1, 32'h13} : {1'b0, 32'hD000_0000 + 32'(i)};
      checks++;
      if ({bq_l[i], bq_d[i]} !== e) begin failures++; $display("FAIL basic_beat%0d: got %h want %h", i, {bq_l[i], bq_d[i]}, e); end
    end
    checks++;
    if (busy !== 1'b0 || n_poll != 2 || n_endb != 1) begin
      failures++; $display("FAIL basic_end: busy=%b polls=%0d endb=%0d want 0/2/1", busy, n_poll, n_endb);
    end
  endtask

  task automatic test_poll_gap;
    logic [32:0] e;
    clear(); endbits = 32'h1F; depth_q = '{32'd0, 32'd0, 32'h142}; m_ready = 1;
    pulse_start();
    for (int i = 0; i < 200 && bq_d.size() < 2; i++) @(negedge clk);
    end_irq = 1;
    wait_done(300);
    end_irq = 0;
    checks++;
    if (n_poll != 5) begin failures++; $display("FAIL gap_polls: got %0d want 5", n_poll); end
    for (int i = 1; i < 3 && i < poll_cyc.size(); i++) begin
      checks++;
      if (poll_cyc[i] - poll_cyc[i-1] != 6 || poll_rq[i] - poll_rq[i-1] != 1) begin
        failures++;
        $display("FAIL gap_spacing%0d: got cycles=%0d req_cycles=%0d want 6/1", i, poll_cyc[i] - poll_cyc[i-1], poll_rq[i] - poll_rq[i-1]);
      end
    end
    checks++;
    if (bq_d.size() != 3) begin failures++; $display("FAIL gap_beats: got %0d want 3", bq_d.size()); end
    for (int i = 0; i < bq_d.size(); i++) begin
      e = i == 2 ? {1'b1, 32'h1F} : {1'b0, 32'hD000_0000 + 32'(i)};
      checks++;
      if ({bq_l[i], bq_d[i]} !== e) begin failures++; $display("FAIL gap_beat%0d: got %h want %h", i, {bq_l[i], bq_d[i]}, e); end
    end
  endtask

  task automatic test_backpressure;
    int nd;
    logic [32:0] e;
    clear(); endbits = 32'h2; depth_q = '{32'd5}; m_ready = 0;
    pulse_start();
    end_irq = 1;
    repeat (10) @(negedge clk);
    nd = n_data;
    m_ready = 1;
    wait_done(300);
    end_irq = 0;
    checks++;
    if (nd != 1) begin failures++; $display("FAIL bp_reads_stalled: got %0d want 1", nd); end
    checks++;
    if (full_rd != 0 || data_moved != 0) begin
      failures++; $display("FAIL bp_hold: full_reads=%0d data_changes=%0d want 0/0", full_rd, data_moved);
    end
    checks++;
    if (bq_d.size() != 6) begin failures++; $display("FAIL bp_beats: got %0d want 6", bq_d.size()); end
    for (int i = 0; i < bq_d.size(); i++) begin
      e = i == 5 ? {1'b1, 32'h2} : {1'b0, 32'hD000_0000 + 32'(i)};
      checks++;
      if ({bq_l[i], bq_d[i]} !== e) begin failures++; $display("FAIL bp_beat%0d: got %h want %h", i, {bq_l[i], bq_d[i]}, e); end
    end
  endtask

  task automatic test_grant_stall;
    logic [32:0] e;
    clear(); endbits = 32'h7; depth_q = '{32'd1}; m_ready = 1; gnt_dly = 6; foreign = 1;
    pulse_start();
    repeat (3) @(negedge clk);
    #4;
    checks++;
    if ({req, add} !== {1'b1, 32'h200}) begin failures++; $display("FAIL stall_req_add: got %h want %h", {req, add}, {1'b1, 32'h200}); end
    end_irq = 1; @(negedge clk); end_irq = 0;
    wait_done(400);
    gnt_dly = 0; foreign = 0;
    checks++;
    if (stall_bad != 0 || n_data != 1) begin
      failures++; $display("FAIL stall_bus: unstable=%0d data_reads=%0d want 0/1", stall_bad, n_data);
    end
    checks++;
    if (bq_d.size() != 2) begin failures++; $display("FAIL stall_beats: got %0d want 2", bq_d.size()); end
    for (int i = 0; i < bq_d.size(); i++) begin
      e = i == 1 ? {1'b1, 32'h7} : {1'b0, 32'hD000_0000};
      checks++;
      if ({bq_l[i], bq_d[i]} !== e) begin failures++; $display("FAIL stall_beat%0d: got %h want %h", i, {bq_l[i], bq_d[i]}, e); end
    end
  endtask

  task automatic test_end_race;
    logic [32:0] e;
    clear(); endbits = 32'hFE5; depth_q = '{32'd2, 32'd0, 32'd1}; m_ready = 1;
    pulse_start();
    for (int i = 0; i < 200 && n_poll < 2; i++) @(negedge clk);
    end_irq = 1; @(negedge clk); end_irq = 0;
    wait_done(300);
    checks++;
    if (n_poll != 4 || n_endb != 1) begin failures++; $display("FAIL race_polls: got %0d/%0d want 4/1", n_poll, n_endb); end
    checks++;
    if (bq_d.size() != 4) begin failures++; $display("FAIL race_beats: got %0d want 4", bq_d.size()); end
    for (int i = 0; i < bq_d.size(); i++) begin
      e = i == 3 ? {1'b1, 32'h5} : {1'b0, 32'hD000_0000 + 32'(i)};
      checks++;
      if ({bq_l[i], bq_d[i]} !== e) begin failures++; $display("FAIL race_beat%0d: got %h want %h", i, {bq_l[i], bq_d[i]}, e); end
    end
  endtask

  task automatic test_reset_mid;
    int d0;
    logic [32:0] e;
    clear(); depth_q = '{32'd2}; m_ready = 1; resp_wait = 6;
    pulse_start();
    for (int i = 0; i < 200 && n_data < 1; i++) @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    #4;
    checks++;
    if ({req, add, wen, be, m_valid, m_data, m_last, busy, done} !== {1'b0, 32'h0, 1'b1, 4'hF, 1'b0, 32'h0, 3'b0}) begin
      failures++; $display("FAIL midrst_outputs: got %h", {req, add, wen, be, m_valid, m_data, m_last, busy, done});
    end
    rst_n = 1;
    repeat (10) @(negedge clk);
    #4;
    checks++;
    if ({req, m_valid, busy, done} !== 4'b0) begin failures++; $display("FAIL midrst_late_rsp: got %b want 0000", {req, m_valid, busy, done}); end
    resp_wait = 0;
    clear(); endbits = 32'h9; depth_q = '{32'd1}; d0 = done_cnt;
    pulse_start();
    end_irq = 1; @(negedge clk); end_irq = 0;
    wait_done(300);
    checks++;
    if (done_cnt - d0 != 1 || bq_d.size() != 2) begin
      failures++; $display("FAIL midrst_restart: done=%0d beats=%0d want 1/2", done_cnt - d0, bq_d.size());
    end
    for (int i = 0; i < bq_d.size(); i++) begin
      e = i == 1 ? {1'b1, 32'h9} : {1'b0, 32'hD000_0000};
      checks++;
      if ({bq_l[i], bq_d[i]} !== e) begin failures++; $display("FAIL midrst_beat%0d: got %h want %h", i, {bq_l[i], bq_d[i]}, e); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_poll_gap();
    test_backpressure();
    test_grant_stall();
    test_end_race();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
